graphics_compositor: RTL and testbench
======================================

Name: graphics_compositor

Overview:
Parametrised successor to the single-layer graphics front end. It owns the VGA timing counters and exports scaled pixel coordinates to game logic. It composites NUM_LAYERS layer-hit inputs by fixed priority through a writable RGB palette, then drives delay-aligned sync and RGB outputs. It also generates the per-frame game tick and a frame counter.

Parameters:
NUM_LAYERS, 4, number of layer-hit inputs; index 0 has the highest priority.
COLOR_BITS, 2, bits per colour channel.
SCALE_LOG2, 1, pixel replication factor is 2^SCALE_LOG2 in both axes (0 disables scaling).
PIPE_DEPTH, 2, register stages from the pixel sample point to the RGB/sync outputs (minimum 1).
H_DISPLAY, 640, visible width.
H_FRONT, 16, horizontal front porch.
H_SYNC, 96, horizontal sync width.
H_BACK, 48, horizontal back porch.
V_DISPLAY, 480, visible height.
V_FRONT, 10, vertical front porch.
V_SYNC, 2, vertical sync width.
V_BACK, 33, vertical back porch.
FRAME_BITS, 8, frame counter width.

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high
i_layer_hit  in  NUM_LAYERS  per-layer coverage of the current o_hpos/o_vpos
i_pal_we  in  1  palette write strobe
i_pal_idx  in  clog2(NUM_LAYERS+1)  palette entry; entry NUM_LAYERS is the background
i_pal_data  in  3*COLOR_BITS  {R,G,B}
o_hpos  out  10-SCALE_LOG2  hcount >> SCALE_LOG2
o_vpos  out  10-SCALE_LOG2  vcount >> SCALE_LOG2
o_hsync  out  1  active-low, pipeline-aligned
o_vsync  out  1  active-low, pipeline-aligned
o_display_on  out  1  pipeline-aligned visible-region flag
o_red, o_green, o_blue  out  COLOR_BITS each  pixel colour
o_game_tick  out  1  one-cycle pulse per frame
o_frame_count  out  FRAME_BITS  completed-frame count

Behaviour:
- Reset is asynchronous, active-high, with clock clk.
- Reset values: hcount=0, vcount=0; all pipeline stages cleared; o_hsync=1, o_vsync=1 (inactive); o_display_on=0; RGB=0; o_game_tick=0; o_frame_count=0.
- Palette reset values: entries 0..NUM_LAYERS-1 = all ones; background entry = all zeros.
- Timing: hcount wraps 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters. vcount increments when hcount wraps and itself wraps 0..V_TOTAL-1.
- Raw sync is active while hcount is in [H_DISPLAY+H_FRONT, +H_SYNC), and likewise for vertical. Raw display_on = (hcount<H_DISPLAY) && (vcount<V_DISPLAY).
- o_hpos/o_vpos are driven combinationally from the counter registers. Game logic returns i_layer_hit in the same cycle.
- Sample/hold: the hit vector is registered only when hcount[SCALE_LOG2-1:0]==0 and held otherwise. With SCALE_LOG2=0 it is sampled every cycle.
- Priority: the lowest set bit of the held vector selects the palette entry. If no bit is set, the background entry is used.
- Pipeline: the palette lookup result passes through PIPE_DEPTH registers. Raw hsync, vsync and display_on pass through a matching delay of PIPE_DEPTH+1 cycles (sample register + PIPE_DEPTH), so every output is aligned.
- Total latency from counter value to output pixel = PIPE_DEPTH+1 cycles.
- Blanking: RGB is forced to 0 whenever the delayed display_on is 0.
- Palette write: a write is visible to lookups starting the next cycle. Mid-frame writes are legal. Pixels already in the pipeline are unaffected. A write with idx > NUM_LAYERS is ignored.
- Game tick: asserted for exactly one cycle when hcount==H_DISPLAY && vcount==V_DISPLAY, i.e. at the start of vertical blank. This pulse is not delayed.
- o_frame_count increments in the same cycle as the tick and wraps at 2^FRAME_BITS.
- Reset mid-frame: counters, pipeline and frame count clear immediately. Palette contents return to their reset values.

Optional Feature:
GRAPHICS_SCANLINE_EN
- Defined: on output lines where the delayed vcount[0]==1, each colour channel is logically shifted right by 1 (scanline dimming). This adds no extra latency; a delayed LSB of vcount travels with the sync pipeline.
- Undefined: the palette colour is output unmodified and the delayed vcount bit is not synthesised.

Test Plan:
- Reset, then run 800*525 cycles with default parameters -> hsync low for 96 cycles per line starting at delayed hcount 656; vsync low for 2 lines; exactly 1 o_game_tick; o_frame_count=1.
- Set i_layer_hit=4'b0110 at hcount=0 -> layer 1 colour (reset value RGB=3,3,3) appears at the output 3 cycles later (PIPE_DEPTH=2); i_layer_hit=0 gives RGB=0,0,0.
- SCALE_LOG2=1, toggle i_layer_hit on every cycle -> output changes only every 2 cycles; the value sampled at even hcount is held for both pixels.
- Write palette idx 4 (background) = 6'b010101 mid-line -> background pixels sampled from the next cycle onward show R=1,G=1,B=1; pixels already in flight keep the old colour; a write with idx=5 leaves the palette unchanged.
- Assert reset at vcount=200, hcount=300 -> all outputs take their reset values within the reset cycle; after release, hcount restarts at 0 and o_frame_count=0.
- With GRAPHICS_SCANLINE_EN defined, all layers at 2'b11 -> even lines output 3, odd lines output 1 per channel.

Source files
------------

// File: rtl/graphics_compositor.sv
// VGA timing, fixed-priority layer compositing through a writable palette, delay-aligned sync/RGB
// outputs, per-frame game tick and frame counter. Define GRAPHICS_SCANLINE_EN for scanline dimming.
module graphics_compositor #(
   parameter int NUM_LAYERS = 4,
   parameter int COLOR_BITS = 2,
   parameter int SCALE_LOG2 = 1,
   parameter int PIPE_DEPTH = 2,
   parameter int H_DISPLAY  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_DISPLAY  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int FRAME_BITS = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_LAYERS-1:0]             i_layer_hit,
   input  logic                              i_pal_we,
   input  logic [$clog2(NUM_LAYERS+1)-1:0]   i_pal_idx,
   input  logic [3*COLOR_BITS-1:0]           i_pal_data,
   output logic [9-SCALE_LOG2:0]             o_hpos,
   output logic [9-SCALE_LOG2:0]             o_vpos,
   output logic                              o_hsync,
   output logic                              o_vsync,
   output logic                              o_display_on,
   output logic [COLOR_BITS-1:0]             o_red,
   output logic [COLOR_BITS-1:0]             o_green,
   output logic [COLOR_BITS-1:0]             o_blue,
   output logic                              o_game_tick,
   output logic [FRAME_BITS-1:0]             o_frame_count
);

   localparam int CNT_W   = 10;
   localparam int IDX_W   = $clog2(NUM_LAYERS + 1);
   localparam int RGB_W   = 3 * COLOR_BITS;
   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_DISP     = CNT_W'(H_DISPLAY);
   localparam logic [CNT_W-1:0] V_DISP     = CNT_W'(V_DISPLAY);
   localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_DISPLAY + H_FRONT);
   localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_DISPLAY + V_FRONT);
   localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);
   localparam logic [CNT_W-1:0] SUB_MASK   = CNT_W'((1 << SCALE_LOG2) - 1);
   localparam logic [IDX_W-1:0] BG_IDX     = IDX_W'(NUM_LAYERS);

   logic [CNT_W-1:0]      r_hcount;
   logic [CNT_W-1:0]      r_vcount;
   logic [FRAME_BITS-1:0] r_frame_count;
   logic [NUM_LAYERS-1:0] r_hit;
   logic [RGB_W-1:0]      r_pal [NUM_LAYERS+1];
   logic [RGB_W-1:0]      r_rgb_pipe [PIPE_DEPTH];

   logic                  w_hsync_raw;
   logic                  w_vsync_raw;
   logic                  w_display_raw;
   logic                  w_sample;
   logic [IDX_W-1:0]      w_sel;
   logic [RGB_W-1:0]      w_lookup;
   logic [RGB_W-1:0]      w_pixel;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hcount <= '0;
         r_vcount <= '0;
      end else if (r_hcount == H_LAST) begin
         r_hcount <= '0;
         r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
      end else begin
         r_hcount <= r_hcount + 1'b1;
      end
   end

   assign o_hpos        = r_hcount[CNT_W-1:SCALE_LOG2];
   assign o_vpos        = r_vcount[CNT_W-1:SCALE_LOG2];
   assign w_hsync_raw   = !((r_hcount >= HS_START) && (r_hcount < HS_END));
   assign w_vsync_raw   = !((r_vcount >= VS_START) && (r_vcount < VS_END));
   assign w_display_raw = (r_hcount < H_DISP) && (r_vcount < V_DISP);

   // Tick decodes the live counters, so it leads the delayed video by the pipeline latency.
   assign o_game_tick   = (r_hcount == H_DISP) && (r_vcount == V_DISP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_frame_count <= '0;
      end else if (o_game_tick) begin
         r_frame_count <= r_frame_count + 1'b1;
      end
   end

   assign o_frame_count = r_frame_count;

   // One sample per replicated pixel block: the hit vector is held across the block.
   assign w_sample = ((r_hcount & SUB_MASK) == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hit <= '0;
      end else if (w_sample) begin
         r_hit <= i_layer_hit;
      end
   end

   // NOTE: always_comb assigns a default before any conditional update, so no latch is inferred.
   always_comb begin
      w_sel = BG_IDX;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (r_hit[i]) w_sel = IDX_W'(i);
      end
   end

   assign w_lookup = r_pal[w_sel];

   // NOTE: the palette is a handful of flops rather than a RAM, so it carries a reset value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_LAYERS; i++) r_pal[i] <= '1;
         r_pal[NUM_LAYERS] <= '0;
      end else if (i_pal_we && (i_pal_idx <= BG_IDX)) begin
         r_pal[i_pal_idx] <= i_pal_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < PIPE_DEPTH; i++) r_rgb_pipe[i] <= '0;
      end else begin
         r_rgb_pipe[0] <= w_lookup;
         for (int i = 1; i < PIPE_DEPTH; i++) r_rgb_pipe[i] <= r_rgb_pipe[i-1];
      end
   end

   // Sync bundle is one stage longer than the colour pipe to cover the hit sample register.
`ifdef GRAPHICS_SCANLINE_EN
   localparam int SB_W = 4;
   logic [SB_W-1:0] w_sync_raw;
   assign w_sync_raw = {r_vcount[0], w_display_raw, w_vsync_raw, w_hsync_raw};
`else
   localparam int SB_W = 3;
   logic [SB_W-1:0] w_sync_raw;
   assign w_sync_raw = {w_display_raw, w_vsync_raw, w_hsync_raw};
`endif
   localparam logic [SB_W-1:0] SB_RESET = SB_W'(3'b011);

   logic [SB_W-1:0] r_sync_pipe [PIPE_DEPTH+1];
   logic [SB_W-1:0] w_sync_out;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i <= PIPE_DEPTH; i++) r_sync_pipe[i] <= SB_RESET;
      end else begin
         r_sync_pipe[0] <= w_sync_raw;
         for (int i = 1; i <= PIPE_DEPTH; i++) r_sync_pipe[i] <= r_sync_pipe[i-1];
      end
   end

   assign w_sync_out   = r_sync_pipe[PIPE_DEPTH];
   assign o_hsync      = w_sync_out[0];
   assign o_vsync      = w_sync_out[1];
   assign o_display_on = w_sync_out[2];

   always_comb begin
      w_pixel = r_rgb_pipe[PIPE_DEPTH-1];
`ifdef GRAPHICS_SCANLINE_EN
      if (w_sync_out[3]) begin
         w_pixel = {w_pixel[3*COLOR_BITS-1:2*COLOR_BITS] >> 1,
                    w_pixel[2*COLOR_BITS-1:COLOR_BITS] >> 1,
                    w_pixel[COLOR_BITS-1:0] >> 1};
      end
`endif
      if (!o_display_on) w_pixel = '0;
   end

   assign o_red   = w_pixel[3*COLOR_BITS-1:2*COLOR_BITS];
   assign o_green = w_pixel[2*COLOR_BITS-1:COLOR_BITS];
   assign o_blue  = w_pixel[COLOR_BITS-1:0];

endmodule

// File: tb/tb_graphics_compositor.sv
// Bench for graphics_compositor: random hits and palette writes against a per-pixel model,
// plus literal checks for reset, priority, palette update timing, frame statistics and mid-frame reset.
module tb_graphics_compositor;

   localparam int NL  = 4;
   localparam int CB  = 2;
   localparam int SL  = 1;
   localparam int PD  = 2;
   localparam int HD  = 40, HF = 4, HS = 6, HB = 6;
   localparam int VD  = 20, VF = 2, VS = 2, VB = 3;
   localparam int HT  = HD + HF + HS + HB;
   localparam int VT  = VD + VF + VS + VB;
   localparam int LAT = PD + 1;
   localparam int IW  = $clog2(NL + 1);

   logic                clk = 1'b0;
   logic                reset;
   logic [NL-1:0]       i_layer_hit = '0;
   logic                i_pal_we = 1'b0;
   logic [IW-1:0]       i_pal_idx = '0;
   logic [3*CB-1:0]     i_pal_data = '0;
   logic [9-SL:0]       o_hpos, o_vpos;
   logic                o_hsync, o_vsync, o_display_on, o_game_tick;
   logic [CB-1:0]       o_red, o_green, o_blue;
   logic [7:0]          o_frame_count;

   graphics_compositor #(
      .NUM_LAYERS(NL), .COLOR_BITS(CB), .SCALE_LOG2(SL), .PIPE_DEPTH(PD),
      .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .FRAME_BITS(8)
   ) dut (
      .clk(clk), .reset(reset), .i_layer_hit(i_layer_hit), .i_pal_we(i_pal_we),
      .i_pal_idx(i_pal_idx), .i_pal_data(i_pal_data), .o_hpos(o_hpos), .o_vpos(o_vpos),
      .o_hsync(o_hsync), .o_vsync(o_vsync), .o_display_on(o_display_on),
      .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
      .o_game_tick(o_game_tick), .o_frame_count(o_frame_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       de;
      logic [5:0] rgb;
   } px_t;

   localparam px_t RST_PX = '{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 6'h00};

   int            total = 0;
   int            bad = 0;
   int            t_next = 0;
   px_t           exp_q[$];
   logic [5:0]    m_pal [NL+1];
   logic [NL-1:0] m_held;
   int            m_frames;
   int            tick_seen, hs_low, vs_low;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h expected=%0h (t=%0d)", name, act, exp, t_next);
      end
   endtask

   function automatic logic [5:0] layer_color(input logic [NL-1:0] hit);
      for (int i = 0; i < NL; i++) if (hit[i]) return m_pal[i];
      return m_pal[NL];
   endfunction

   // Model: pixel t lands on the outputs LAT cycles later; colour uses the palette as it stands
   // after any write in the pixel's own cycle.
   always @(negedge clk) begin : cmp_proc
      int  h, v;
      px_t e, p;
      if (reset) begin
         check("rst_hsync", o_hsync, 1);
         check("rst_vsync", o_vsync, 1);
         check("rst_de", o_display_on, 0);
         check("rst_rgb", {o_red, o_green, o_blue}, 0);
         check("rst_tick", o_game_tick, 0);
         check("rst_frames", o_frame_count, 0);
         check("rst_hpos", o_hpos, 0);
         check("rst_vpos", o_vpos, 0);
         t_next = 0;
         exp_q.delete();
         for (int i = 0; i < LAT; i++) exp_q.push_back(RST_PX);
         for (int i = 0; i < NL; i++) m_pal[i] = '1;
         m_pal[NL] = '0;
         m_held = '0;
         m_frames = 0;
         tick_seen = 0;
         hs_low = 0;
         vs_low = 0;
      end else begin
         h = t_next % HT;
         v = (t_next / HT) % VT;
         check("hpos", o_hpos, h >> SL);
         check("vpos", o_vpos, v >> SL);
         check("tick", o_game_tick, (h == HD && v == VD) ? 1 : 0);
         check("frames", o_frame_count, m_frames % 256);
         e = exp_q.pop_front();
         check("hsync", o_hsync, e.hs);
         check("vsync", o_vsync, e.vs);
         check("de", o_display_on, e.de);
         check("rgb", {o_red, o_green, o_blue}, e.rgb);
         if (t_next >= LAT && t_next < LAT + HT * VT) begin
            if (!o_hsync) hs_low++;
            if (!o_vsync) vs_low++;
         end
         if (o_game_tick) tick_seen++;

         if (i_pal_we && i_pal_idx <= NL) m_pal[i_pal_idx] = i_pal_data;
         if (h % (1 << SL) == 0) m_held = i_layer_hit;
         p.hs  = !(h >= HD + HF && h < HD + HF + HS);
         p.vs  = !(v >= VD + VF && v < VD + VF + VS);
         p.de  = (h < HD) && (v < VD);
         p.rgb = p.de ? layer_color(m_held) : 6'h00;
`ifdef GRAPHICS_SCANLINE_EN
         if (v % 2 == 1) p.rgb = {p.rgb[5:4] >> 1, p.rgb[3:2] >> 1, p.rgb[1:0] >> 1};
`endif
         exp_q.push_back(p);
         if (h == HD && v == VD) m_frames++;
         t_next++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycle(input int n);
      int guard = 0;
      while (t_next != n && guard < 6000) begin
         step();
         guard++;
      end
      if (t_next != n) begin
         total++;
         bad++;
         $display("FAIL wait_cycle: actual=%0d required=%0d", t_next, n);
      end
   endtask

   task automatic check_rgb_at(input int n, input string name, input logic [5:0] exp);
      wait_cycle(n);
      @(negedge clk);
      #1;
      check(name, {o_red, o_green, o_blue}, exp);
   endtask

   task automatic random_until(input int n);
      while (t_next < n) begin
         i_layer_hit = ($urandom_range(0, 3) == 0) ? '0 : NL'($urandom_range(0, (1 << NL) - 1));
         i_pal_we    = ($urandom_range(0, 15) == 0);
         i_pal_idx   = IW'($urandom_range(0, 7));
         i_pal_data  = 6'($urandom);
         step();
      end
      i_layer_hit = '0;
      i_pal_we    = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b, r;
      reset = 1'b0;
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;

      // Layer 1 wins over layer 2; reset palette gives all ones.
      b = 2 * HT;
      wait_cycle(b);
      i_layer_hit = 4'b0110;
      step();
      i_layer_hit = 4'b0000;
      check_rgb_at(b + LAT, "layer1_first", 6'h3F);
      check_rgb_at(b + LAT + 1, "layer1_held", 6'h3F);
      check_rgb_at(b + LAT + 2, "no_hit_bg", 6'h00);

      // Background rewrite mid-line; the pixel already looked up keeps the old colour.
      b = 4 * HT + 10;
      wait_cycle(b);
      i_pal_we = 1'b1; i_pal_idx = IW'(4); i_pal_data = 6'b010101;
      step();
      i_pal_we = 1'b0;
      check_rgb_at(b - 1 + LAT, "bg_in_flight", 6'h00);
      check_rgb_at(b + LAT, "bg_new", 6'h15);
      wait_cycle(b + 6);
      i_pal_we = 1'b1; i_pal_idx = IW'(5); i_pal_data = 6'h3F;
      step();
      i_pal_we = 1'b0;
      check_rgb_at(b + 6 + LAT + 2, "bg_idx5_ignored", 6'h15);

      // Random traffic through the end of the first frame, then frame statistics.
      step();
      random_until(HT * VT + LAT + 5);
      check("frame1_count", o_frame_count, 1);
      check("frame1_ticks", tick_seen, 1);
      check("frame1_hs_low", hs_low, HS * VT);
      check("frame1_vs_low", vs_low, VS * HT);

      random_until(2 * HT * VT + 20);
      check("frame2_count", o_frame_count, 2);

      // Mid-frame reset.
      r = 2 * HT * VT + 15 * HT + 30;
      random_until(r);
      reset = 1'b1;
      @(negedge clk);
      #1;
      check("midrst_hsync", o_hsync, 1);
      check("midrst_de", o_display_on, 0);
      check("midrst_rgb", {o_red, o_green, o_blue}, 0);
      check("midrst_frames", o_frame_count, 0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      check_rgb_at(2, "post_rst_rgb", 6'h00);
      check("post_rst_hpos", o_hpos, 1);
      check("post_rst_frames", o_frame_count, 0);
      step();
      random_until(400);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
